// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types for the SPI serial-clock engine
// Purpose: FSM state encoding and SPI mode encoding {cpol,cpha} with small
//          accessors used by the engine.
// Ports:   none (package)
package spi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_RUN   = 2'd2,
      ST_HOLD  = 2'd3
   } spi_state_e;

   // Mode number is {cpol,cpha}, so MODE1 = cpol 0 / cpha 1, MODE3 = both set.
   typedef enum logic [1:0] {
      SPI_MODE0 = 2'b00,
      SPI_MODE1 = 2'b01,
      SPI_MODE2 = 2'b10,
      SPI_MODE3 = 2'b11
   } spi_mode_e;

   function automatic spi_mode_e make_mode(input logic cpol, input logic cpha);
      return spi_mode_e'({cpol, cpha});
   endfunction

   function automatic logic mode_cpol(input spi_mode_e m);
      logic [1:0] b;
      b = m;
      return b[1];
   endfunction

   function automatic logic mode_cpha(input spi_mode_e m);
      logic [1:0] b;
      b = m;
      return b[0];
   endfunction

endpackage

// File: rtl/spi_baud_tick.sv
// rtl/spi_baud_tick.sv - sclk half-period down-counter
// Purpose: counts div clk cycles per half-period and pulses tick on the last
//          cycle of each half-period, reloading itself on that cycle.
// Ports:   clk/rst  clock and asynchronous active-high reset
//          load     reload the counter from div (held while the frame is in setup)
//          enable   count while the frame is running
//          div      half-period length in clk cycles, 0 treated as 1
//          tick     one-cycle pulse: next cycle carries a new sclk level
module spi_baud_tick #(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             enable,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   logic [DIV_W-1:0] cnt_q;
   logic [DIV_W-1:0] cnt_d;
   logic [DIV_W-1:0] reload;

   always_comb begin
      reload = (div == '0) ? DIV_W'(1) : div;
      tick   = enable && (cnt_q == DIV_W'(1));
      cnt_d  = cnt_q;
      if (load) begin
         cnt_d = reload;
      end else if (enable) begin
         // Reloading at 1 (and defensively at 0) keeps the count from ever
         // wrapping through all-ones inside a half-period.
         if (cnt_q <= DIV_W'(1)) begin
            cnt_d = reload;
         end else begin
            cnt_d = cnt_q - DIV_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/spi_sclk_engine.sv
// rtl/spi_sclk_engine.sv - SPI master serial-clock, chip-select and strobe engine
// Purpose: generates cs_n and sclk for one DATA_W-bit frame per accepted start,
//          with sample/shift strobes aligned to the sclk edges for all modes.
// Ports:   clk/rst      clock and asynchronous active-high reset
//          cpol/cpha    SPI mode, latched at frame start
//          div          sclk half-period in clk cycles (0 acts as 1), latched
//          start        frame request, honoured only while tx_ready is high
//          tx_ready     idle and able to accept start
//          busy         frame in progress
//          done         one-cycle end-of-frame pulse (with cs_n rise)
//          cs_n, sclk   SPI chip select and serial clock
//          sample_edge  strobe coincident with a sampling sclk edge
//          shift_edge   strobe coincident with a shifting sclk edge
//          bit_cnt      sample strobes seen in the current frame
module spi_sclk_engine
   import spi_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int DIV_W    = 8,
   parameter int CS_SETUP = 1,
   parameter int CS_HOLD  = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        cpol,
   input  logic                        cpha,
   input  logic [DIV_W-1:0]            div,
   input  logic                        start,
   output logic                        tx_ready,
   output logic                        busy,
   output logic                        done,
   output logic                        cs_n,
   output logic                        sclk,
   output logic                        sample_edge,
   output logic                        shift_edge,
   output logic [$clog2(DATA_W+1)-1:0] bit_cnt
);

   localparam int BCW    = $clog2(DATA_W + 1);
   localparam int EDGE_W = $clog2(2 * DATA_W + 1);
   localparam int SET_W  = $clog2(CS_SETUP + 1);
   localparam int HLD_W  = $clog2(CS_HOLD + 1);

   localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W);
   localparam logic [BCW-1:0]    BIT_MAX   = BCW'(DATA_W);
   localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(CS_SETUP - 1);
   localparam logic [HLD_W-1:0]  HLD_LAST  = HLD_W'(CS_HOLD - 1);

   spi_state_e        state_q, state_d;
   spi_mode_e         mode_q, mode_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic              cs_n_q, cs_n_d;
   logic              sclk_q, sclk_d;
   logic              tx_ready_q, tx_ready_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              sample_q, sample_d;
   logic              shift_q, shift_d;
   logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [EDGE_W-1:0] edge_cnt_q, edge_cnt_d;
   logic [SET_W-1:0]  setup_cnt_q, setup_cnt_d;
   logic [HLD_W-1:0]  hold_cnt_q, hold_cnt_d;

   logic              baud_load;
   logic              baud_en;
   logic              tick;
   logic [EDGE_W-1:0] next_edge;
   logic              is_sample;

   // The counter is preloaded through every setup cycle so the first
   // half-period starts counting on the first RUN cycle.
   assign baud_load = (state_q == ST_SETUP);
   assign baud_en   = (state_q == ST_RUN);

   spi_baud_tick #(
      .DIV_W (DIV_W)
   ) u_baud_tick (
      .clk    (clk),
      .rst    (rst),
      .load   (baud_load),
      .enable (baud_en),
      .div    (div_q),
      .tick   (tick)
   );

   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      div_d       = div_q;
      cs_n_d      = cs_n_q;
      sclk_d      = sclk_q;
      tx_ready_d  = tx_ready_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      sample_d    = 1'b0;
      shift_d     = 1'b0;
      bit_cnt_d   = bit_cnt_q;
      edge_cnt_d  = edge_cnt_q;
      setup_cnt_d = setup_cnt_q;
      hold_cnt_d  = hold_cnt_q;

      // Odd edge numbers are leading edges; cpha moves sampling to trailing.
      next_edge = edge_cnt_q + EDGE_W'(1);
      is_sample = next_edge[0] ^ mode_cpha(mode_q);

      case (state_q)
         ST_IDLE: begin
            cs_n_d     = 1'b1;
            busy_d     = 1'b0;
            tx_ready_d = 1'b1;
            sclk_d     = cpol;
            // done_q gates out a start in the done cycle; tx_ready_q keeps the
            // first cycle after reset from accepting one.
            if (start && tx_ready_q && !done_q) begin
               mode_d      = make_mode(cpol, cpha);
               div_d       = (div == '0) ? DIV_W'(1) : div;
               state_d     = ST_SETUP;
               cs_n_d      = 1'b0;
               busy_d      = 1'b1;
               tx_ready_d  = 1'b0;
               bit_cnt_d   = '0;
               edge_cnt_d  = '0;
               setup_cnt_d = '0;
            end
         end

         ST_SETUP: begin
            if (setup_cnt_q == SET_LAST) begin
               state_d = ST_RUN;
            end else begin
               setup_cnt_d = setup_cnt_q + SET_W'(1);
            end
         end

         ST_RUN: begin
            if (tick) begin
               sclk_d     = ~sclk_q;
               edge_cnt_d = next_edge;
               sample_d   = is_sample;
               // With cpha=0 the final trailing edge would shift a bit that
               // does not exist, so it carries no strobe.
               shift_d    = !is_sample && (next_edge != LAST_EDGE);
               if (is_sample && (bit_cnt_q != BIT_MAX)) begin
                  bit_cnt_d = bit_cnt_q + BCW'(1);
               end
               if (next_edge == LAST_EDGE) begin
                  state_d    = ST_HOLD;
                  hold_cnt_d = '0;
               end
            end
         end

         ST_HOLD: begin
            sclk_d = mode_cpol(mode_q);
            if (hold_cnt_q == HLD_LAST) begin
               state_d    = ST_IDLE;
               cs_n_d     = 1'b1;
               done_d     = 1'b1;
               busy_d     = 1'b0;
               tx_ready_d = 1'b1;
               sclk_d     = cpol;
            end else begin
               hold_cnt_d = hold_cnt_q + HLD_W'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         mode_q      <= SPI_MODE0;
         div_q       <= '0;
         cs_n_q      <= 1'b1;
         sclk_q      <= 1'b0;
         tx_ready_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         sample_q    <= 1'b0;
         shift_q     <= 1'b0;
         bit_cnt_q   <= '0;
         edge_cnt_q  <= '0;
         setup_cnt_q <= '0;
         hold_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         div_q       <= div_d;
         cs_n_q      <= cs_n_d;
         sclk_q      <= sclk_d;
         tx_ready_q  <= tx_ready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         sample_q    <= sample_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         edge_cnt_q  <= edge_cnt_d;
         setup_cnt_q <= setup_cnt_d;
         hold_cnt_q  <= hold_cnt_d;
      end
   end

   assign tx_ready    = tx_ready_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign cs_n        = cs_n_q;
   assign sclk        = sclk_q;
   assign sample_edge = sample_q;
   assign shift_edge  = shift_q;
   assign bit_cnt     = bit_cnt_q;

endmodule

// File: tb/tb_spi_sclk_engine.sv
// tb/tb_spi_sclk_engine.sv - directed self-checking bench for spi_sclk_engine
module tb_spi_sclk_engine;

   logic       clk = 1'b0;
   logic       rst;
   logic       cpol;
   logic       cpha;
   logic [7:0] div;
   logic       start;
   logic       sel16;
   logic       start8;
   logic       start16;

   logic       tx_ready8, busy8, done8, cs_n8, sclk8, samp8, shift8;
   logic [3:0] bc8;
   logic       tx_ready16, busy16, done16, cs_n16, sclk16, samp16, shift16;
   logic [4:0] bc16;

   logic        o_tx_ready, o_busy, o_done, o_cs_n, o_sclk, o_sample, o_shift;
   logic [31:0] o_bc;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   assign start8  = start & ~sel16;
   assign start16 = start & sel16;

   assign o_tx_ready = sel16 ? tx_ready16 : tx_ready8;
   assign o_busy     = sel16 ? busy16     : busy8;
   assign o_done     = sel16 ? done16     : done8;
   assign o_cs_n     = sel16 ? cs_n16     : cs_n8;
   assign o_sclk     = sel16 ? sclk16     : sclk8;
   assign o_sample   = sel16 ? samp16     : samp8;
   assign o_shift    = sel16 ? shift16    : shift8;
   assign o_bc       = sel16 ? 32'(bc16)  : 32'(bc8);

   spi_sclk_engine #(.DATA_W(8), .DIV_W(8), .CS_SETUP(1), .CS_HOLD(1)) dut8 (
      .clk         (clk),
      .rst         (rst),
      .cpol        (cpol),
      .cpha        (cpha),
      .div         (div),
      .start       (start8),
      .tx_ready    (tx_ready8),
      .busy        (busy8),
      .done        (done8),
      .cs_n        (cs_n8),
      .sclk        (sclk8),
      .sample_edge (samp8),
      .shift_edge  (shift8),
      .bit_cnt     (bc8)
   );

   spi_sclk_engine #(.DATA_W(16), .DIV_W(8), .CS_SETUP(1), .CS_HOLD(1)) dut16 (
      .clk         (clk),
      .rst         (rst),
      .cpol        (cpol),
      .cpha        (cpha),
      .div         (div),
      .start       (start16),
      .tx_ready    (tx_ready16),
      .busy        (busy16),
      .done        (done16),
      .cs_n        (cs_n16),
      .sclk        (sclk16),
      .sample_edge (samp16),
      .shift_edge  (shift16),
      .bit_cnt     (bc16)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Starts a frame in the current cycle (cycle 0) and checks every output on
   // cycles 1..last+1 against the edge timing 2 + n*d.
   task automatic run_frame(input logic pol, input logic pha, input int div_in,
                            input int d, input int w, input bit keep,
                            input int chg_at, input int chg_div,
                            output int done_at, output int n_samp,
                            output int n_shift, output int last_edge);
      int   last;
      int   k;
      bit   is_edge;
      bit   e_samp;
      bit   e_shift;
      logic prev;
      last      = 2 + 2 * w * d;
      done_at   = -1;
      n_samp    = 0;
      n_shift   = 0;
      last_edge = -1;
      prev      = pol;
      chk("frame_c0_tx_ready", o_tx_ready, 1);
      cpol  = pol;
      cpha  = pha;
      div   = 8'(div_in);
      start = 1'b1;
      for (int c = 1; c <= last + 1; c++) begin
         tick();
         if (c == 1 && !keep) start = 1'b0;
         if (c == chg_at) div = 8'(chg_div);
         if (c <= last) begin
            k       = (c < 2 + d) ? 0 : (c - 2) / d;
            is_edge = (c >= 2 + d) && ((c - 2) % d == 0);
         end else begin
            k       = 2 * w;
            is_edge = 1'b0;
         end
         e_samp  = is_edge && (pha ? (k % 2 == 0) : (k % 2 == 1));
         e_shift = is_edge && !e_samp && (k != 2 * w);
         chk($sformatf("sclk@%0d", c),     o_sclk,     32'(pol ^ (k % 2 == 1)));
         chk($sformatf("cs_n@%0d", c),     o_cs_n,     32'(c > last));
         chk($sformatf("busy@%0d", c),     o_busy,     32'(c <= last));
         chk($sformatf("tx_ready@%0d", c), o_tx_ready, 32'(c > last));
         chk($sformatf("done@%0d", c),     o_done,     32'(c == last + 1));
         chk($sformatf("sample@%0d", c),   o_sample,   32'(e_samp));
         chk($sformatf("shift@%0d", c),    o_shift,    32'(e_shift));
         chk($sformatf("bit_cnt@%0d", c),  o_bc,       32'(pha ? k / 2 : (k + 1) / 2));
         if (o_done === 1'b1) done_at = c;
         if (o_sample === 1'b1) n_samp++;
         if (o_shift === 1'b1) n_shift++;
         if (o_sclk !== prev) last_edge = c;
         prev = o_sclk;
      end
   endtask

   int done_at, ns, nsh, le;

   initial begin
      rst   = 1'b1;
      cpol  = 1'b0;
      cpha  = 1'b0;
      div   = 8'd2;
      start = 1'b0;
      sel16 = 1'b0;
      tick();
      tick();
      chk("rst_tx_ready", o_tx_ready, 0);
      chk("rst_cs_n",     o_cs_n,     1);
      chk("rst_sclk",     o_sclk,     0);
      chk("rst_busy",     o_busy,     0);
      chk("rst_done",     o_done,     0);
      chk("rst_bit_cnt",  o_bc,       0);
      chk("rst_strobes",  32'(o_sample | o_shift), 0);
      rst = 1'b0;
      tick();
      chk("post_rst_tx_ready", o_tx_ready, 1);
      idle(2);

      // Mode 0, div=2
      run_frame(1'b0, 1'b0, 2, 2, 8, 1'b0, 0, 0, done_at, ns, nsh, le);
      chk("m0_done_at",   done_at, 35);
      chk("m0_samples",   ns,      8);
      chk("m0_shifts",    nsh,     7);
      chk("m0_last_edge", le,      34);

      // Mode 3, div=2
      cpol = 1'b1;
      cpha = 1'b1;
      idle(2);
      chk("m3_idle_sclk", o_sclk, 1);
      run_frame(1'b1, 1'b1, 2, 2, 8, 1'b0, 0, 0, done_at, ns, nsh, le);
      chk("m3_done_at",   done_at, 35);
      chk("m3_samples",   ns,      8);
      chk("m3_shifts",    nsh,     8);
      chk("m3_last_edge", le,      34);

      // div=0 behaves as div=1
      cpol = 1'b0;
      cpha = 1'b0;
      idle(2);
      run_frame(1'b0, 1'b0, 0, 1, 8, 1'b0, 0, 0, done_at, ns, nsh, le);
      chk("d0_done_at",   done_at, 19);
      chk("d0_last_edge", le,      18);

      // start held high: back-to-back frames, div changes mid-frame ignored
      idle(2);
      run_frame(1'b0, 1'b0, 2, 2, 8, 1'b1, 10, 5, done_at, ns, nsh, le);
      chk("b2b1_done_at", done_at, 35);
      tick();
      chk("b2b_gap_cs_n", o_cs_n, 1);
      chk("b2b_gap_done", o_done, 0);
      run_frame(1'b0, 1'b0, 5, 5, 8, 1'b0, 20, 1, done_at, ns, nsh, le);
      chk("b2b2_done_at", done_at, 83);
      div = 8'd2;
      idle(3);

      // rst pulsed at cycle 12 of a mode 0 frame
      chk("ra_c0_tx_ready", o_tx_ready, 1);
      cpol  = 1'b0;
      cpha  = 1'b0;
      div   = 8'd2;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("ra_c1_cs_n", o_cs_n, 0);
      idle(11);
      chk("ra_c12_sclk_pre", o_sclk, 1);
      rst = 1'b1;
      #1;
      chk("ra_cs_n",     o_cs_n,     1);
      chk("ra_sclk",     o_sclk,     0);
      chk("ra_tx_ready", o_tx_ready, 0);
      chk("ra_busy",     o_busy,     0);
      chk("ra_bit_cnt",  o_bc,       0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk("ra_post_tx_ready", o_tx_ready, 1);
      chk("ra_post_sclk",     o_sclk,     0);
      for (int i = 0; i < 36; i++) begin
         chk($sformatf("ra_no_done@%0d", i), o_done, 0);
         tick();
      end

      // DATA_W=16, div=3, mode 1
      sel16 = 1'b1;
      cpol  = 1'b0;
      cpha  = 1'b1;
      div   = 8'd3;
      idle(2);
      run_frame(1'b0, 1'b1, 3, 3, 16, 1'b0, 0, 0, done_at, ns, nsh, le);
      chk("w16_done_at",   done_at, 99);
      chk("w16_last_edge", le,      98);
      chk("w16_samples",   ns,      16);
      chk("w16_shifts",    nsh,     16);
      chk("w16_bit_cnt",   o_bc,    16);
      sel16 = 1'b0;
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_sclk_engine.md
SPI_SCLK_ENGINE -- requirements
Module: spi_sclk_engine

Interface
REQ-001 Parameters SHALL be as follows; values outside the stated ranges are illegal:
- DATA_W, default 8, bits per frame (1..16).
- DIV_W, default 8, width of the divider input.
- CS_SETUP, default 1, clk cycles from cs_n fall to the start of the first half-period (>=1).
- CS_HOLD, default 1, clk cycles from the last sclk edge to cs_n rise (>=1).
REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpol  in  1  idle sclk level.
- cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge.
- div  in  DIV_W  sclk half-period in clk cycles; 0 is treated as 1.
- start  in  1  frame request; sampled only while tx_ready=1.
- tx_ready  out  1  engine idle and able to accept start.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse at end of frame.
- cs_n  out  1  active-low chip select.
- sclk  out  1  serial clock.
- sample_edge  out  1  one-cycle strobe coincident with a sampling sclk edge.
- shift_edge  out  1  one-cycle strobe coincident with a shifting sclk edge.
- bit_cnt  out  $clog2(DATA_W+1)  count of sample_edge strobes in the current frame.

Function
REQ-003 The FSM SHALL have four states, IDLE, SETUP, RUN and HOLD, with all outputs registered.
REQ-004 In IDLE: tx_ready=1, busy=0, cs_n=1, sclk follows cpol with one cycle of latency, and strobes=0.
REQ-005 In IDLE, start=1 at cycle T SHALL latch cpol, cpha and div (div=0 latched as 1). At T+1 the outputs SHALL be state SETUP, cs_n=0, busy=1, tx_ready=0, bit_cnt=0.
REQ-006 start SHALL be ignored in every state except IDLE; the latched configuration SHALL NOT change mid-frame.
REQ-007 SETUP SHALL last CS_SETUP cycles, after which the FSM enters RUN.
REQ-008 Sclk edge n (n=1..2*DATA_W) SHALL be visible at T+1+CS_SETUP+n*div.
REQ-009 Odd n SHALL be a leading edge (rising if cpol=0) and even n a trailing edge.
REQ-010 If cpha=0: sample_edge SHALL pulse on leading edges, and shift_edge SHALL pulse on trailing edges except the final edge (DATA_W-1 shift pulses).
REQ-011 If cpha=1: shift_edge SHALL pulse on leading edges and sample_edge on trailing edges (DATA_W pulses each).
REQ-012 Strobes SHALL assert in the same cycle the new sclk level appears; sample_edge and shift_edge SHALL never assert together.
REQ-013 bit_cnt SHALL increment in the cycle each sample_edge is visible and saturate at DATA_W.
REQ-014 After edge 2*DATA_W the FSM SHALL enter HOLD with sclk at the latched cpol. After CS_HOLD cycles: cs_n=1, done=1 for one cycle, busy=0, tx_ready=1, state IDLE.
REQ-015 start asserted in the cycle done pulses SHALL be ignored; start is accepted from the following cycle.
REQ-016 The half-period counter SHALL be DIV_W bits wide, reload on each edge, and never wrap mid-half-period.

Reset
REQ-017 While rst=1, regardless of state: state=IDLE, sclk=0, cs_n=1, tx_ready=0, busy=0, done=0, strobes=0, bit_cnt=0, and all counters cleared.
REQ-018 Assertion of rst mid-frame SHALL abort the frame with no done pulse. tx_ready=1 and sclk=cpol SHALL be visible one cycle after rst deasserts.

Structure
REQ-019 A shared spi_pkg SHALL hold the state enum (IDLE/SETUP/RUN/HOLD) and the SPI mode encoding {cpol,cpha}.
REQ-020 The half-period divider SHALL be the sub-module spi_baud_tick (load, enable, div in; one-cycle tick out).

Verification
REQ-021 The bench SHALL cover these directed scenarios (default parameters, div=2, start at cycle 0 unless stated):
- Mode 0: cs_n falls at 1; edges at 4,6,...,34; rising edges at 4,8,...,32; sample_edge at 4,8,...,32 (8 pulses); shift_edge at 6,...,30 (7 pulses); done and cs_n rise at 35.
- Mode 3 (cpol=1, cpha=1): sclk idles 1; falling edge at 4; shift_edge at 4,8,...,32; sample_edge at 6,...,34; bit_cnt=8 at 34.
- div=0: edges on consecutive cycles from 3 to 18; done at 19.
- start held high continuously: back-to-back frames; cs_n high for at least one cycle between frames; div change mid-frame has no effect.
- rst pulsed at cycle 12 in mode 0: cs_n=1 and sclk=0 immediately; no done pulse; tx_ready=1 one cycle after rst deasserts.
- DATA_W=16, div=3, mode 1: 32 edges; last edge at 98; done at 99; bit_cnt=16.
